// File: rtl/comm_pkg.sv
// rtl/comm_pkg.sv - shared opcodes, error codes, deframer state and frame sizing for the comm path
package comm_pkg;

  localparam logic [2:0] COMM_INVALID           = 3'd0;
  localparam logic [2:0] COMM_READ_ENABLE_MASK  = 3'd1;
  localparam logic [2:0] COMM_READ_PIN_MAP      = 3'd2;
  localparam logic [2:0] COMM_WRITE_ENABLE_MASK = 3'd3;
  localparam logic [2:0] COMM_WRITE_PIN_MAP     = 3'd4;

  localparam logic [1:0] ERR_BAD_OP  = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_HOLD    = 2'd2
  } deframer_state_e;

  // Payload size in bytes of a write-enable-mask (is_map=0) or write-pin-map (is_map=1) frame.
  function automatic int payload_bytes(input bit is_map, input int output_count,
                                       input int input_count);
    int n;
    if (is_map) n = $clog2(input_count) * output_count / 8;
    else        n = output_count / 8;
    return n;
  endfunction

endpackage

// File: rtl/cmd_deframer_if.sv
// rtl/cmd_deframer_if.sv - complete-frame valid/ready handshake between deframer and register logic
interface cmd_deframer_if #(
  parameter int PAY_W = 32
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [PAY_W-1:0] cmd_payload;
  logic [3:0]       cmd_len;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_payload,
    output cmd_len,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_payload,
    input  cmd_len,
    output cmd_ready
  );
endinterface

// File: rtl/cmd_deframer_gap_timer.sv
// rtl/cmd_deframer_gap_timer.sv - reloadable saturating down-counter with a single-cycle expire pulse
module gap_timer #(
  parameter int CYCLES = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expire
);
  localparam int W = $clog2(CYCLES + 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= W'(CYCLES);
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  // Fires on the edge that would take the count from 1 to 0; a saturated zero never re-fires.
  assign expire = en && !load && (count == W'(1));

endmodule

// File: rtl/cmd_deframer.sv
// rtl/cmd_deframer.sv - assembles opcode plus payload bytes into one atomic command frame
module cmd_deframer
  import comm_pkg::*;
#(
  parameter int OUTPUT_COUNT   = 16,
  parameter int INPUT_COUNT    = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rx_valid,
  input  logic [7:0]         rx_byte,
  cmd_deframer_if.master     cmd,
  output logic               err_valid,
  output logic [1:0]         err_code
);
  localparam int EN_BYTES  = payload_bytes(1'b0, OUTPUT_COUNT, INPUT_COUNT);
  localparam int MAP_BYTES = payload_bytes(1'b1, OUTPUT_COUNT, INPUT_COUNT);
  localparam int PAY_BYTES = (EN_BYTES > MAP_BYTES) ? EN_BYTES : MAP_BYTES;
  localparam int PAY_W     = 8 * PAY_BYTES;

  deframer_state_e  state;
  logic             valid_q;
  logic [2:0]       op_q;
  logic [PAY_W-1:0] payload_q;
  logic [3:0]       len_q;
  logic [3:0]       byte_cnt;

  logic is_read_op;
  logic is_write_op;
  logic timer_load;
  logic timer_en;
  logic timer_expire;

  always_comb begin
    is_read_op  = (rx_byte == 8'(COMM_READ_ENABLE_MASK)) || (rx_byte == 8'(COMM_READ_PIN_MAP));
    is_write_op = (rx_byte == 8'(COMM_WRITE_ENABLE_MASK)) || (rx_byte == 8'(COMM_WRITE_PIN_MAP));
    timer_load  = rx_valid && (((state == ST_IDLE) && is_write_op) || (state == ST_PAYLOAD));
    timer_en    = (state == ST_PAYLOAD) && !rx_valid;
  end

  gap_timer #(
    .CYCLES(TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (timer_load),
    .en     (timer_en),
    .expire (timer_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      valid_q   <= 1'b0;
      op_q      <= COMM_INVALID;
      payload_q <= '0;
      len_q     <= '0;
      byte_cnt  <= '0;
      err_valid <= 1'b0;
      err_code  <= 2'd0;
    end else begin
      err_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_valid) begin
            if (is_read_op) begin
              op_q      <= rx_byte[2:0];
              len_q     <= '0;
              payload_q <= '0;
              valid_q   <= 1'b1;
              state     <= ST_HOLD;
            end else if (is_write_op) begin
              op_q      <= rx_byte[2:0];
              payload_q <= '0;
              byte_cnt  <= '0;
              len_q     <= (rx_byte == 8'(COMM_WRITE_ENABLE_MASK)) ? 4'(EN_BYTES) : 4'(MAP_BYTES);
              state     <= ST_PAYLOAD;
            end else begin
              err_valid <= 1'b1;
              err_code  <= ERR_BAD_OP;
            end
          end
        end

        ST_PAYLOAD: begin
          if (timer_expire) begin
            err_valid <= 1'b1;
            err_code  <= ERR_TIMEOUT;
            state     <= ST_IDLE;
          end else if (rx_valid) begin
            for (int i = 0; i < PAY_BYTES; i++) begin
              if (byte_cnt == 4'(i)) payload_q[8*i +: 8] <= rx_byte;
            end
            byte_cnt <= byte_cnt + 4'd1;
            if (byte_cnt == len_q - 4'd1) begin
              valid_q <= 1'b1;
              state   <= ST_HOLD;
            end
          end
        end

        ST_HOLD: begin
          // The frame is frozen here; anything arriving is dropped, even on the accept cycle.
          if (rx_valid) begin
            err_valid <= 1'b1;
            err_code  <= ERR_OVERRUN;
          end
          if (cmd.cmd_ready) begin
            valid_q <= 1'b0;
            state   <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cmd.cmd_valid   = valid_q;
  assign cmd.cmd_op      = op_q;
  assign cmd.cmd_payload = payload_q;
  assign cmd.cmd_len     = len_q;

endmodule

// File: tb/tb_cmd_deframer.sv
// tb/tb_cmd_deframer.sv - randomized self-checking bench for cmd_deframer
`timescale 1ns/1ps
module tb_cmd_deframer;
  localparam int OUTPUT_COUNT = 16;
  localparam int INPUT_COUNT  = 4;
  localparam int TO           = 32;
  localparam int EN_B         = OUTPUT_COUNT / 8;
  localparam int MAP_B        = $clog2(INPUT_COUNT) * OUTPUT_COUNT / 8;

  typedef struct packed {
    logic [2:0]  op;
    logic [3:0]  len;
    logic [31:0] payload;
  } frame_t;

  logic       clk;
  logic       rst_n;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       err_valid;
  logic [1:0] err_code;

  int n_checks = 0;
  int n_fail   = 0;

  frame_t     frame_log[$];
  logic [1:0] err_log[$];

  cmd_deframer_if #(.PAY_W(32)) cmd_bus ();

  cmd_deframer #(
    .OUTPUT_COUNT   (OUTPUT_COUNT),
    .INPUT_COUNT    (INPUT_COUNT),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_valid  (rx_valid),
    .rx_byte   (rx_byte),
    .cmd       (cmd_bus),
    .err_valid (err_valid),
    .err_code  (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (err_valid) err_log.push_back(err_code);
    if (cmd_bus.cmd_valid && cmd_bus.cmd_ready)
      frame_log.push_back('{op: cmd_bus.cmd_op, len: cmd_bus.cmd_len, payload: cmd_bus.cmd_payload});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00; cmd_bus.cmd_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    n_checks++; if (cmd_bus.cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", cmd_bus.cmd_valid); end
    n_checks++; if (cmd_bus.cmd_op !== 3'd0) begin n_fail++; $display("FAIL reset_op got %0d want 0", cmd_bus.cmd_op); end
    n_checks++; if (cmd_bus.cmd_payload !== 32'd0) begin n_fail++; $display("FAIL reset_payload got %h want 0", cmd_bus.cmd_payload); end
    n_checks++; if (cmd_bus.cmd_len !== 4'd0) begin n_fail++; $display("FAIL reset_len got %0d want 0", cmd_bus.cmd_len); end
    n_checks++; if (err_valid !== 1'b0 || err_code !== 2'd0) begin n_fail++; $display("FAIL reset_err got %b/%0d want 0/0", err_valid, err_code); end
  endtask

  task automatic test_read_opcode();
    int bf = frame_log.size();
    cmd_bus.cmd_ready = 1'b1;
    put_byte(8'h01);
    n_checks++; if (cmd_bus.cmd_valid !== 1'b1) begin n_fail++; $display("FAIL read_valid got %b want 1", cmd_bus.cmd_valid); end
    n_checks++; if (cmd_bus.cmd_op !== 3'd1 || cmd_bus.cmd_len !== 4'd0) begin n_fail++; $display("FAIL read_fields got op %0d len %0d want 1/0", cmd_bus.cmd_op, cmd_bus.cmd_len); end
    tick();
    n_checks++; if (cmd_bus.cmd_valid !== 1'b0) begin n_fail++; $display("FAIL read_drop got %b want 0", cmd_bus.cmd_valid); end
    n_checks++; if (frame_log.size() != bf + 1) begin n_fail++; $display("FAIL read_count got %0d want %0d", frame_log.size() - bf, 1); end
  endtask

  task automatic test_write_map();
    cmd_bus.cmd_ready = 1'b0;
    put_byte(8'h04); put_byte(8'hAA); put_byte(8'hBB); put_byte(8'hCC);
    n_checks++; if (cmd_bus.cmd_valid !== 1'b0) begin n_fail++; $display("FAIL map_early_valid got %b want 0", cmd_bus.cmd_valid); end
    put_byte(8'hDD);
    n_checks++; if (cmd_bus.cmd_valid !== 1'b1) begin n_fail++; $display("FAIL map_valid got %b want 1", cmd_bus.cmd_valid); end
    n_checks++; if (cmd_bus.cmd_payload !== 32'hDDCCBBAA) begin n_fail++; $display("FAIL map_payload got %h want DDCCBBAA", cmd_bus.cmd_payload); end
    n_checks++; if (cmd_bus.cmd_op !== 3'd4 || cmd_bus.cmd_len !== 4'd4) begin n_fail++; $display("FAIL map_fields got op %0d len %0d want 4/4", cmd_bus.cmd_op, cmd_bus.cmd_len); end
    cmd_bus.cmd_ready = 1'b1;
    tick();
    n_checks++; if (cmd_bus.cmd_valid !== 1'b0) begin n_fail++; $display("FAIL map_accept got %b want 0", cmd_bus.cmd_valid); end
  endtask

  task automatic test_backpressure_overrun();
    int be = err_log.size();
    int bf = frame_log.size();
    int ovr = 0;
    cmd_bus.cmd_ready = 1'b0;
    put_byte(8'h03); put_byte(8'h12); put_byte(8'h34);
    for (int c = 0; c < 10; c++) begin
      if (c == 5) begin
        put_byte(8'h02);
        n_checks++; if (err_valid !== 1'b1 || err_code !== 2'd3) begin n_fail++; $display("FAIL bp_overrun_pulse got %b/%0d want 1/3", err_valid, err_code); end
      end else begin
        tick();
      end
      n_checks++; if (cmd_bus.cmd_valid !== 1'b1 || cmd_bus.cmd_payload !== 32'h3412 || cmd_bus.cmd_op !== 3'd3) begin
        n_fail++; $display("FAIL bp_hold cycle %0d got v%b op %0d pay %h want v1 op 3 pay 3412", c, cmd_bus.cmd_valid, cmd_bus.cmd_op, cmd_bus.cmd_payload);
      end
    end
    for (int i = be; i < err_log.size(); i++) if (err_log[i] == 2'd3) ovr++;
    n_checks++; if (ovr != 1 || err_log.size() != be + 1) begin n_fail++; $display("FAIL bp_overrun_count got %0d of %0d want 1", ovr, err_log.size() - be); end
    cmd_bus.cmd_ready = 1'b1;
    tick();
    n_checks++; if (cmd_bus.cmd_valid !== 1'b0) begin n_fail++; $display("FAIL bp_accept got %b want 0", cmd_bus.cmd_valid); end
    n_checks++; if (frame_log.size() != bf + 1 || frame_log[frame_log.size()-1].payload !== 32'h3412) begin
      n_fail++; $display("FAIL bp_frame got %0d frames want 1 with payload 3412", frame_log.size() - bf);
    end
  endtask

  task automatic test_back_to_back();
    int bf = frame_log.size();
    cmd_bus.cmd_ready = 1'b1;
    put_byte(8'h01);
    put_byte(8'h02);
    n_checks++; if (err_valid !== 1'b1 || err_code !== 2'd3) begin n_fail++; $display("FAIL b2b_overrun got %b/%0d want 1/3", err_valid, err_code); end
    n_checks++; if (cmd_bus.cmd_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_dropped got %b want 0", cmd_bus.cmd_valid); end
    put_byte(8'h02);
    n_checks++; if (cmd_bus.cmd_valid !== 1'b1 || cmd_bus.cmd_op !== 3'd2) begin n_fail++; $display("FAIL b2b_next got v%b op %0d want v1 op 2", cmd_bus.cmd_valid, cmd_bus.cmd_op); end
    tick();
    n_checks++; if (frame_log.size() != bf + 2) begin n_fail++; $display("FAIL b2b_count got %0d want 2", frame_log.size() - bf); end
  endtask

  task automatic test_timeout();
    int be;
    logic saw_valid = 1'b0;
    logic early = 1'b0;
    cmd_bus.cmd_ready = 1'b1;
    put_byte(8'h03); put_byte(8'h55);
    for (int c = 0; c < TO - 1; c++) begin
      tick();
      if (cmd_bus.cmd_valid) saw_valid = 1'b1;
      if (err_valid) early = 1'b1;
    end
    n_checks++; if (early !== 1'b0) begin n_fail++; $display("FAIL to_early got %b want 0", early); end
    tick();
    n_checks++; if (err_valid !== 1'b1 || err_code !== 2'd2) begin n_fail++; $display("FAIL to_pulse got %b/%0d want 1/2", err_valid, err_code); end
    n_checks++; if (saw_valid !== 1'b0 || cmd_bus.cmd_valid !== 1'b0) begin n_fail++; $display("FAIL to_valid got %b want 0", saw_valid | cmd_bus.cmd_valid); end
    tick();
    n_checks++; if (err_valid !== 1'b0) begin n_fail++; $display("FAIL to_single got %b want 0", err_valid); end
    put_byte(8'h01);
    n_checks++; if (cmd_bus.cmd_valid !== 1'b1 || cmd_bus.cmd_op !== 3'd1) begin n_fail++; $display("FAIL to_recover got v%b op %0d want v1 op 1", cmd_bus.cmd_valid, cmd_bus.cmd_op); end
    tick();
    be = err_log.size();
    put_byte(8'h03);
    repeat (TO - 1) tick();
    put_byte(8'h66);
    repeat (TO - 1) tick();
    put_byte(8'h77);
    n_checks++; if (cmd_bus.cmd_valid !== 1'b1 || cmd_bus.cmd_payload !== 32'h7766) begin
      n_fail++; $display("FAIL to_edge_frame got v%b pay %h want v1 pay 7766", cmd_bus.cmd_valid, cmd_bus.cmd_payload);
    end
    n_checks++; if (err_log.size() != be) begin n_fail++; $display("FAIL to_edge_err got %0d want 0", err_log.size() - be); end
    tick();
  endtask

  task automatic test_bad_opcodes();
    logic [7:0] bad[4] = '{8'h00, 8'h07, 8'hFF, 8'h05};
    for (int k = 0; k < 4; k++) begin
      put_byte(bad[k]);
      n_checks++; if (err_valid !== 1'b1 || err_code !== 2'd1 || cmd_bus.cmd_valid !== 1'b0) begin
        n_fail++; $display("FAIL badop_%h got err %b/%0d valid %b want 1/1 valid 0", bad[k], err_valid, err_code, cmd_bus.cmd_valid);
      end
    end
    tick();
    n_checks++; if (err_valid !== 1'b0) begin n_fail++; $display("FAIL badop_single got %b want 0", err_valid); end
  endtask

  task automatic test_reset_mid_frame();
    int be = err_log.size();
    cmd_bus.cmd_ready = 1'b0;
    put_byte(8'h04); put_byte(8'h11);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (cmd_bus.cmd_valid !== 1'b0 || cmd_bus.cmd_op !== 3'd0 || cmd_bus.cmd_payload !== 32'd0 || cmd_bus.cmd_len !== 4'd0) begin
      n_fail++; $display("FAIL rst_outputs got v%b op %0d pay %h len %0d want all 0", cmd_bus.cmd_valid, cmd_bus.cmd_op, cmd_bus.cmd_payload, cmd_bus.cmd_len);
    end
    n_checks++; if (err_valid !== 1'b0 || err_code !== 2'd0) begin n_fail++; $display("FAIL rst_err got %b/%0d want 0/0", err_valid, err_code); end
    #2 rst_n = 1'b1;
    tick();
    put_byte(8'h03); put_byte(8'h01); put_byte(8'h02);
    n_checks++; if (cmd_bus.cmd_valid !== 1'b1 || cmd_bus.cmd_payload !== 32'h0201) begin
      n_fail++; $display("FAIL rst_after got v%b pay %h want v1 pay 0201", cmd_bus.cmd_valid, cmd_bus.cmd_payload);
    end
    n_checks++; if (err_log.size() != be) begin n_fail++; $display("FAIL rst_no_err got %0d want 0", err_log.size() - be); end
    cmd_bus.cmd_ready = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic [7:0] stream[$];
    frame_t     exp_f[$];
    int         exp_bad = 0;
    int         bf = frame_log.size();
    int         be = err_log.size();
    int         i = 0;
    cmd_bus.cmd_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      int r = $urandom_range(0, 9);
      if (r == 0) stream.push_back(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(5, 255)));
      else if (r < 4) stream.push_back(8'($urandom_range(1, 2)));
      else begin
        logic [7:0] op = 8'($urandom_range(3, 4));
        stream.push_back(op);
        for (int k = 0; k < ((op == 8'h03) ? EN_B : MAP_B); k++) stream.push_back(8'($urandom));
      end
    end
    // Reference: walk the byte stream by the opcode rules alone.
    while (i < stream.size()) begin
      logic [7:0]  b = stream[i];
      logic [31:0] p = 32'd0;
      int          n;
      i++;
      if (b == 8'h01 || b == 8'h02) exp_f.push_back('{op: b[2:0], len: 4'd0, payload: 32'd0});
      else if (b == 8'h03 || b == 8'h04) begin
        n = (b == 8'h03) ? EN_B : MAP_B;
        for (int k = 0; k < n; k++) p = p + (32'(stream[i+k]) << (8 * k));
        i += n;
        exp_f.push_back('{op: b[2:0], len: 4'(n), payload: p});
      end else exp_bad++;
    end
    foreach (stream[k]) begin
      put_byte(stream[k]);
      repeat ($urandom_range(1, 4)) tick();
    end
    repeat (3) tick();
    n_checks++; if (frame_log.size() - bf != exp_f.size()) begin n_fail++; $display("FAIL rand_frames got %0d want %0d", frame_log.size() - bf, exp_f.size()); end
    for (int k = 0; k < exp_f.size() && bf + k < frame_log.size(); k++) begin
      frame_t g = frame_log[bf+k];
      n_checks++;
      if (g.op !== exp_f[k].op || g.len !== exp_f[k].len || (exp_f[k].len != 0 && g.payload !== exp_f[k].payload)) begin
        n_fail++; $display("FAIL rand_frame_%0d got op %0d len %0d pay %h want op %0d len %0d pay %h", k, g.op, g.len, g.payload, exp_f[k].op, exp_f[k].len, exp_f[k].payload);
      end
    end
    n_checks++; if (err_log.size() - be != exp_bad) begin n_fail++; $display("FAIL rand_errs got %0d want %0d", err_log.size() - be, exp_bad); end
    for (int k = be; k < err_log.size(); k++) begin
      n_checks++; if (err_log[k] !== 2'd1) begin n_fail++; $display("FAIL rand_err_code got %0d want 1", err_log[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_read_opcode();
    test_write_map();
    test_backpressure_overrun();
    test_back_to_back();
    test_timeout();
    test_bad_opcodes();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
